mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequential arbiter and transaction sequencer that lets the instruction-fetch stage and the data-memory (MEM) stage share one single-ported, variable-latency memory. It accepts one outstanding request per requester, grants the port to one requester at a time, holds the transaction stable until the memory signals ready, and returns data with a one-cycle acknowledge. It sits between the pipeline (PC/IF and EX/MEM stages) and the memory. It also drives a stall that the hazard logic uses to freeze PC, IF/ID and the later pipeline registers.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive data grants tolerated while a fetch is pending (used only with MEM_ARB_FAIR_EN)

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset; synchronous, active-high
- start_i  in  1  run enable; low blocks new grants
- if_req_i  in  1  fetch request; held until if_ack_o
- if_addr_i  in  ADDR_W  fetch address
- if_rdata_o  out  DATA_W  fetched instruction; valid with if_ack_o
- if_ack_o  out  1  one-cycle fetch completion pulse
- dm_req_i  in  1  data request; held until dm_ack_o
- dm_we_i  in  1  1 = write, 0 = read
- dm_addr_i  in  ADDR_W  data address
- dm_wdata_i  in  DATA_W  store data
- dm_rdata_o  out  DATA_W  load data; valid with dm_ack_o
- dm_ack_o  out  1  one-cycle data completion pulse
- mem_req_o  out  1  memory transaction active
- mem_we_o  out  1  memory write strobe
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_rdata_i  in  DATA_W  memory read data; sampled when mem_ready_i is high
- mem_ready_i  in  1  memory completes the current transaction this cycle
- stall_o  out  1  pipeline freeze request
- busy_o  out  1  FSM not in IDLE

## Operation
- FSM states: IDLE, BUSY_IF, BUSY_DM, RESP.
- IDLE, with start_i=1:
  - dm_req_i -> BUSY_DM. Default priority is data over fetch, because the data request belongs to the older instruction.
  - Otherwise if_req_i -> BUSY_IF.
  - Otherwise stay in IDLE.
- Grant edge: requester address, we and wdata are captured into output registers. mem_* outputs are registered and stay stable for the whole busy state.
- BUSY_x:
  - mem_req_o=1; mem_we_o=dm_we captured for BUSY_DM, 0 for BUSY_IF.
  - On mem_ready_i=1: capture mem_rdata_i into the granted requester's rdata register (reads only), then go to RESP.
- RESP:
  - Exactly one of if_ack_o / dm_ack_o is high; mem_req_o=0.
  - Requests are ignored in RESP, so a stale held request is never re-granted.
  - Next state is IDLE.
- Writes: dm_ack_o is still pulsed; dm_rdata_o keeps its previous value.
- rdata outputs hold their value until the next read completion for that requester.
- stall_o = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o), combinational.
- busy_o = (state != IDLE).
- start_i low: no grant is issued from IDLE. An in-flight transaction still completes through RESP.

## Timing
- Reset values: all outputs 0, state IDLE, starvation counter 0.
- Latency:
  - Request seen in IDLE at cycle 0 -> mem_req_o high from cycle 1.
  - mem_ready_i high in cycle k (k≥1) -> ack pulse in cycle k+1.
  - IDLE in cycle k+2.
  - Minimum turnaround is 3 cycles per transaction.
- mem_ready_i is ignored outside the BUSY states.
- Simultaneous if_req_i and dm_req_i in IDLE -> data wins (subject to Configuration). The fetch stays pending and is granted from the next IDLE.
- rst_i mid-transaction: next cycle is IDLE with all outputs 0. The in-flight memory access is abandoned, and the memory must tolerate mem_req_o dropping.
- Request inputs change while BUSY: no effect on the mem_* outputs.

## Configuration
- MEM_ARB_FAIR_EN defined:
  - A counter increments on each data grant made while if_req_i is pending.
  - It clears on any fetch grant and when if_req_i is low at a grant.
  - When the count equals STARVE_LIMIT, the next IDLE grant goes to fetch even if dm_req_i is high.
- MEM_ARB_FAIR_EN undefined:
  - Strict data-over-fetch priority.
  - No counter is present and STARVE_LIMIT is unused.

## Structure
- Shared package cpu_mem_pkg holds:
  - the FSM state enum (IDLE, BUSY_IF, BUSY_DM, RESP);
  - the grant-owner encoding;
  - ADDR_W/DATA_W default constants.
- Optional sub-module arb_starve_ctr: a saturating counter with limit compare, instantiated only under MEM_ARB_FAIR_EN.

## Test plan
- Single fetch, if_addr_i=0x10, mem_ready_i one cycle after mem_req_o rises, mem_rdata_i=0x00A00093 -> mem_addr_o=0x10, if_ack_o in the next cycle with if_rdata_o=0x00A00093, stall_o low after the ack.
- Simultaneous if_req_i (addr 0x20) and dm_req_i (read 0x100, memory returns 0x5) -> data served first with dm_rdata_o=0x5, then fetch 0x20 granted; no grant in either RESP cycle.
- Store dm_we_i=1, addr 0x8, wdata 0xDEADBEEF, mem_ready_i after 3 cycles -> mem_we_o/mem_wdata_o stable for all 3 busy cycles, dm_ack_o pulse, dm_rdata_o unchanged.
- rst_i asserted during BUSY_DM -> next cycle all outputs 0, busy_o=0; no ack is ever produced for the abandoned request.
- start_i=0 with if_req_i=1 -> mem_req_o stays 0 and stall_o=1; start_i rising -> grant next cycle.
- MEM_ARB_FAIR_EN, STARVE_LIMIT=2, dm_req_i continuously re-asserted and if_req_i held -> grant order DM, DM, IF; with the macro undefined -> IF is never granted while dm_req_i is high.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared types and defaults for the IF/MEM memory port arbiter.
package cpu_mem_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StBusyIf = 2'd1,
        StBusyDm = 2'd2,
        StResp   = 2'd3
    } arb_state_e;

    // Owner of the port for the transaction being granted.
    typedef enum logic {
        OwnIf = 1'b0,
        OwnDm = 1'b1
    } owner_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive data grants made while a fetch waits.
// at_limit_o tells the arbiter to hand the next grant to fetch.
module arb_starve_ctr #(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_limit_o
);

    localparam int unsigned CntW = $clog2(LIMIT + 1);
    localparam logic [CntW-1:0] LimitVal = CntW'(LIMIT);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Next count: clear wins over increment, saturate at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LimitVal)) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit_o = (cnt_q == LimitVal);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between instruction fetch
// and the data stage. Data wins by default; defining MEM_ARB_FAIR_EN adds a
// starvation counter that forces a fetch grant after STARVE_LIMIT data grants.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ack_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ack_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ready_i,
    output logic              stall_o,
    output logic              busy_o
);

    arb_state_e        state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              if_ack_q, if_ack_d;
    logic              dm_ack_q, dm_ack_d;

    logic   grant_fire;
    logic   fair_force;
    owner_e grant_owner;

    assign grant_owner = (dm_req_i && !fair_force) ? OwnDm : OwnIf;
    assign grant_fire  = (state_q == StIdle) && start_i && (if_req_i || dm_req_i);

`ifdef MEM_ARB_FAIR_EN
    localparam int unsigned CtrLimit = (STARVE_LIMIT == 0) ? 1 : STARVE_LIMIT;

    logic ctr_inc;
    logic ctr_clr;
    logic at_limit;

    // Any grant that is not a data grant over a waiting fetch breaks the streak.
    assign ctr_inc = grant_fire && (grant_owner == OwnDm) && if_req_i;
    assign ctr_clr = grant_fire && !ctr_inc;

    arb_starve_ctr #(
        .LIMIT(CtrLimit)
    ) u_starve_ctr (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .inc_i     (ctr_inc),
        .clr_i     (ctr_clr),
        .at_limit_o(at_limit)
    );

    assign fair_force = at_limit && if_req_i;
`else
    assign fair_force = 1'b0;
`endif

    // Next-state and registered-output logic; mem_* only change at grant or completion.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;

        case (state_q)
            StIdle: begin
                if (grant_fire) begin
                    mem_req_d = 1'b1;
                    if (grant_owner == OwnDm) begin
                        state_d     = StBusyDm;
                        mem_we_d    = dm_we_i;
                        mem_addr_d  = dm_addr_i;
                        mem_wdata_d = dm_wdata_i;
                    end else begin
                        state_d     = StBusyIf;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr_i;
                        mem_wdata_d = '0;
                    end
                end
            end
            StBusyIf: begin
                if (mem_ready_i) begin
                    state_d    = StResp;
                    mem_req_d  = 1'b0;
                    if_rdata_d = mem_rdata_i;
                    if_ack_d   = 1'b1;
                end
            end
            StBusyDm: begin
                if (mem_ready_i) begin
                    state_d   = StResp;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    // Stores leave the last load value visible.
                    if (!mem_we_q) begin
                        dm_rdata_d = mem_rdata_i;
                    end
                    dm_ack_d = 1'b1;
                end
            end
            // Held requests are ignored here so a completed one is never re-granted.
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight access.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign if_rdata_o  = if_rdata_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign if_ack_o    = if_ack_q;
    assign dm_ack_o    = dm_ack_q;
    assign busy_o      = (state_q != StIdle);
    assign stall_o     = (if_req_i && !if_ack_q) || (dm_req_i && !dm_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: requester and memory agents drive
// stimulus and push expected read data; a monitor checks grants, timing and
// returned data against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

    localparam int unsigned Limit   = 2;
    localparam int unsigned NCycles = 3000;
`ifdef MEM_ARB_FAIR_EN
    localparam bit Fair = 1'b1;
`else
    localparam bit Fair = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_i, start_i;
    logic        if_req_i, dm_req_i, dm_we_i, mem_ready_i;
    logic [31:0] if_addr_i, dm_addr_i, dm_wdata_i, mem_rdata_i;
    logic [31:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;
    logic        if_ack_o, dm_ack_o, mem_req_o, mem_we_o, stall_o, busy_o;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .STARVE_LIMIT(Limit)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .if_req_i   (if_req_i),
        .if_addr_i  (if_addr_i),
        .if_rdata_o (if_rdata_o),
        .if_ack_o   (if_ack_o),
        .dm_req_i   (dm_req_i),
        .dm_we_i    (dm_we_i),
        .dm_addr_i  (dm_addr_i),
        .dm_wdata_i (dm_wdata_i),
        .dm_rdata_o (dm_rdata_o),
        .dm_ack_o   (dm_ack_o),
        .mem_req_o  (mem_req_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i),
        .mem_ready_i(mem_ready_i),
        .stall_o    (stall_o),
        .busy_o     (busy_o)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [31:0] if_exp_q[$];
    logic [31:0] dm_exp_q[$];
    int unsigned if_acks = 0, dm_acks = 0;
    int unsigned if_wait = 0, dm_wait = 0, if_wait_max = 0, dm_wait_max = 0;

    // Memory contents are a fixed function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h00A0_0093;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: model of the previous cycle and the transaction in flight.
    logic        p_valid = 1'b0;
    logic        p_rst, p_start, p_ifreq, p_dmreq, p_dmwe, p_ready;
    logic [31:0] p_ifaddr, p_dmaddr, p_dmwdata;
    logic        p_memreq = 1'b0, p_ifack = 1'b0, p_dmack = 1'b0;
    logic        cur_dm = 1'b0;
    logic [31:0] t_addr = '0, t_wdata = '0;
    logic        t_we = 1'b0;
    logic [31:0] last_if = '0, last_dm = '0;
    int unsigned streak = 0;

    initial begin : monitor
        logic e_req, e_ifack, e_dmack;
        logic [31:0] exp_v;
        forever begin
            @(negedge clk);
            e_req   = 1'b0;
            e_ifack = 1'b0;
            e_dmack = 1'b0;
            if (p_valid) begin
                if (p_rst) begin
                    check("rst_mem_addr", mem_addr_o, 32'h0);
                    check("rst_mem_we", {31'b0, mem_we_o}, 32'h0);
                    check("rst_mem_wdata", mem_wdata_o, 32'h0);
                    if_exp_q.delete();
                    dm_exp_q.delete();
                    streak  = 0;
                    last_if = '0;
                    last_dm = '0;
                end else if (!p_memreq && !p_ifack && !p_dmack) begin
                    // Port free: a grant must follow any enabled pending request.
                    if (p_start && (p_ifreq || p_dmreq)) begin
                        e_req   = 1'b1;
                        cur_dm  = p_dmreq && !(Fair && (streak == Limit) && p_ifreq);
                        t_addr  = cur_dm ? p_dmaddr : p_ifaddr;
                        t_we    = cur_dm ? p_dmwe : 1'b0;
                        t_wdata = p_dmwdata;
                        check("grant_addr", mem_addr_o, t_addr);
                        check("grant_we", {31'b0, mem_we_o}, {31'b0, t_we});
                        if (t_we) check("grant_wdata", mem_wdata_o, t_wdata);
                        if (cur_dm && p_ifreq) streak = (streak < Limit) ? streak + 1 : streak;
                        else streak = 0;
                    end
                end else if (p_memreq) begin
                    if (p_ready) begin
                        e_ifack = !cur_dm;
                        e_dmack = cur_dm;
                    end else begin
                        e_req = 1'b1;
                        check("hold_addr", mem_addr_o, t_addr);
                        check("hold_we", {31'b0, mem_we_o}, {31'b0, t_we});
                        if (t_we) check("hold_wdata", mem_wdata_o, t_wdata);
                    end
                end
                check("mem_req", {31'b0, mem_req_o}, {31'b0, e_req});
                check("if_ack", {31'b0, if_ack_o}, {31'b0, e_ifack});
                check("dm_ack", {31'b0, dm_ack_o}, {31'b0, e_dmack});
                check("stall", {31'b0, stall_o},
                      {31'b0, (if_req_i && !e_ifack) || (dm_req_i && !e_dmack)});
                check("busy", {31'b0, busy_o}, {31'b0, e_req || e_ifack || e_dmack});
                if (if_ack_o) begin
                    if (if_exp_q.size() == 0) begin
                        check("if_sb_underflow", {31'b0, if_ack_o}, 32'h0);
                    end else begin
                        exp_v   = if_exp_q.pop_front();
                        last_if = exp_v;
                        if_acks++;
                    end
                end
                if (dm_ack_o) begin
                    if (dm_exp_q.size() == 0) begin
                        check("dm_sb_underflow", {31'b0, dm_ack_o}, 32'h0);
                    end else begin
                        exp_v   = dm_exp_q.pop_front();
                        last_dm = exp_v;
                        dm_acks++;
                    end
                end
                check("if_rdata", if_rdata_o, last_if);
                check("dm_rdata", dm_rdata_o, last_dm);
            end
            if (if_req_i && !if_ack_o) if_wait++;
            else if_wait = 0;
            if (dm_req_i && !dm_ack_o) dm_wait++;
            else dm_wait = 0;
            if (if_wait > if_wait_max) if_wait_max = if_wait;
            if (dm_wait > dm_wait_max) dm_wait_max = dm_wait;
            p_valid   = 1'b1;
            p_rst     = rst_i;
            p_start   = start_i;
            p_ifreq   = if_req_i;
            p_dmreq   = dm_req_i;
            p_dmwe    = dm_we_i;
            p_ifaddr  = if_addr_i;
            p_dmaddr  = dm_addr_i;
            p_dmwdata = dm_wdata_i;
            p_ready   = mem_ready_i;
            p_memreq  = e_req;
            p_ifack   = e_ifack;
            p_dmack   = e_dmack;
        end
    end

    // Stimulus: requester agents, memory agent, run enable and reset injection.
    initial begin : stimulus
        logic        a_if, a_dm, in_win;
        logic [31:0] dm_last;
        int unsigned if_gap, dm_gap;
        bit          rst_armed;
        rst_i       = 1'b1;
        start_i     = 1'b0;
        if_req_i    = 1'b0;
        dm_req_i    = 1'b0;
        dm_we_i     = 1'b0;
        if_addr_i   = '0;
        dm_addr_i   = '0;
        dm_wdata_i  = '0;
        mem_ready_i = 1'b0;
        mem_rdata_i = '0;
        dm_last     = '0;
        if_gap      = 0;
        dm_gap      = 0;
        rst_armed   = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        for (int cyc = 0; cyc < NCycles; cyc++) begin
            @(negedge clk);
            a_if = if_ack_o;
            a_dm = dm_ack_o;
            @(posedge clk);
            #1;
            in_win = (cyc >= 1200) && (cyc < 1400);
            if (cyc == 700 || cyc == 1900) rst_armed = 1'b1;
            if (rst_i) begin
                rst_i    = 1'b0;
                if_req_i = 1'b0;
                dm_req_i = 1'b0;
                if_gap   = 1 + $urandom_range(0, 2);
                dm_gap   = 1 + $urandom_range(0, 2);
                dm_last  = '0;
            end else if (rst_armed && mem_req_o && dm_req_i && (mem_addr_o == dm_addr_i)) begin
                rst_armed = 1'b0;
                rst_i     = 1'b1;
            end else begin
                if (if_req_i && a_if) begin
                    if_req_i = 1'b0;
                    if_gap   = in_win ? 0 : $urandom_range(0, 3);
                end
                if (!if_req_i) begin
                    if (if_gap == 0) begin
                        if_addr_i = $urandom & 32'hFFFF_FFFC;
                        if_exp_q.push_back(mem_word(if_addr_i));
                        if_req_i = 1'b1;
                    end else begin
                        if_gap--;
                    end
                end
                if (dm_req_i && a_dm) begin
                    dm_req_i = 1'b0;
                    dm_gap   = in_win ? 0 : $urandom_range(0, 3);
                end
                if (!dm_req_i) begin
                    if (dm_gap == 0) begin
                        dm_we_i    = $urandom_range(0, 1) == 1;
                        dm_addr_i  = $urandom & 32'hFFFF_FFFC;
                        dm_wdata_i = $urandom;
                        if (!dm_we_i) dm_last = mem_word(dm_addr_i);
                        dm_exp_q.push_back(dm_last);
                        dm_req_i = 1'b1;
                    end else begin
                        dm_gap--;
                    end
                end
            end
            start_i     = in_win || ($urandom_range(0, 7) != 0);
            mem_ready_i = $urandom_range(0, 2) == 0;
            mem_rdata_i = mem_ready_i ? mem_word(mem_addr_o) : $urandom;
        end
        repeat (2) @(negedge clk);
        check("if_progress", {31'b0, if_acks > 100}, 32'h1);
        check("dm_progress", {31'b0, dm_acks > 100}, 32'h1);
        check("if_wait_bound", {31'b0, if_wait_max < 400}, 32'h1);
        check("dm_wait_bound", {31'b0, dm_wait_max < 100}, 32'h1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
